// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mul_arb_pkg;
  localparam int OP_W     = 32;
  localparam int PROD_W   = 64;
  localparam int MAX_NREQ = 8;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } tag_t;

  localparam tag_t TAG_IDLE = '{vld: 1'b0, idx: 3'd0};
endpackage

// File: rtl/mul_tag_pipe.sv
// Valid/requester-index delay line; the output tag lines up with the multiplier product.
module mul_tag_pipe
  import mul_arb_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] tag_i,
  output logic [3:0] tag_o
);

  tag_t pipe_q [DEPTH];

  // shift register, flushed to invalid tags on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= TAG_IDLE;
    end else begin
      pipe_q[0] <= tag_t'(tag_i);
      for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier among NREQ requesters.
// Optional statistics counters are enabled with the MUL_ARB_STATS_EN macro.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int NREQ        = 4,
  parameter  int MUL_LATENCY = 6,
  localparam int IDX_W       = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*PROD_W-1:0] rsp_result,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]      mul_result,
`ifdef MUL_ARB_STATS_EN
  output logic [31:0]            issue_count,
  output logic [31:0]            stall_count,
`endif
  output logic                   busy
);

  logic [NREQ-1:0]        elig_s, grant_s, cap_s;
  logic [IDX_W-1:0]       win_s;
  logic                   hs_s;
  int                     cand_s;
  tag_t                   tag_out_s;

  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [OP_W-1:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  tag_t                   tag_q, tag_d;
  logic [NREQ-1:0]        inflight_q, inflight_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NREQ*PROD_W-1:0] rsp_result_q, rsp_result_d;
  logic                   busy_q, busy_d;

  assign elig_s = req_valid & ~inflight_q & ~rsp_valid_q;

  // round-robin search: descending offsets so the nearest eligible index to rr_q wins last
  always_comb begin
    grant_s = '0;
    win_s   = '0;
    hs_s    = 1'b0;
    cand_s  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = (int'(rr_q) + k) % NREQ;
      win_s  = elig_s[cand_s] ? IDX_W'(cand_s) : win_s;
      hs_s   = elig_s[cand_s] | hs_s;
    end
    hs_s           = hs_s & ~reset;
    grant_s[win_s] = hs_s;
  end

  // capture strobe per requester from the tag aligned with mul_result
  always_comb begin
    cap_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      cap_s[i] = tag_out_s.vld & (tag_out_s.idx == 3'(i));
    end
  end

  // next state for issue path, response holding registers and inflight mask
  always_comb begin
    rr_d       = hs_s ? ((win_s == IDX_W'(NREQ - 1)) ? '0 : win_s + IDX_W'(1)) : rr_q;
    mul_a_d    = hs_s ? req_a[OP_W*win_s +: OP_W] : '0;
    mul_b_d    = hs_s ? req_b[OP_W*win_s +: OP_W] : '0;
    tag_d.vld  = hs_s;
    tag_d.idx  = hs_s ? 3'(win_s) : 3'd0;
    inflight_d = (inflight_q | grant_s) & ~cap_s;
    rsp_valid_d  = (rsp_valid_q & ~rsp_ready) | cap_s;
    rsp_result_d = rsp_result_q;
    for (int i = 0; i < NREQ; i++) begin
      rsp_result_d[PROD_W*i +: PROD_W] = cap_s[i] ? mul_result : rsp_result_q[PROD_W*i +: PROD_W];
    end
    busy_d = (|inflight_d) | (|rsp_valid_d);
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_q        <= TAG_IDLE;
      inflight_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      busy_q       <= busy_d;
    end
  end

  mul_tag_pipe #(.DEPTH(MUL_LATENCY)) u_tag_pipe (
    .clk_i (clk),
    .rst_i (reset),
    .tag_i (tag_q),
    .tag_o (tag_out_s)
  );

`ifdef MUL_ARB_STATS_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  // handshake and blocked-cycle counters, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      issue_cnt_q <= issue_cnt_q + {31'd0, hs_s};
      stall_cnt_q <= stall_cnt_q + {31'd0, (|req_valid) & ~hs_s};
    end
  end

  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

  assign req_ready  = grant_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a behavioural pipelined multiplier.
// Statistics checks are compiled in when MUL_ARB_STATS_EN is defined.
module tb_mul_share_arbiter;
  localparam int NREQ = 4;
  localparam int L    = 6;

  logic            clk, reset;
  logic [3:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0]    req_a, req_b;
  logic [255:0]    rsp_result;
  logic [31:0]     mul_a, mul_b;
  logic [63:0]     mul_result;
  logic            busy;
`ifdef MUL_ARB_STATS_EN
  logic [31:0]     issue_count, stall_count;
`endif

  mul_share_arbiter #(.NREQ(NREQ), .MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
`ifdef MUL_ARB_STATS_EN
    .issue_count(issue_count), .stall_count(stall_count),
`endif
    .busy(busy)
  );

  typedef struct { int idx; logic [63:0] prod; int cyc; } exp_t;
  exp_t sb[$];
  int   grant_q[$];
  int   n_chk = 0, n_err = 0, cyc = 0, rise_cnt = 0, exp_issue = 0, exp_stall = 0;
  int   hs_cnt[4], last_hs_cyc[4], left[4];
  logic [3:0]  hs_last = 4'd0, rsp_prev = 4'd0;
  logic [63:0] mp [L];

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #200000; $display("FAIL watchdog: got timeout expected finish"); $fatal(1); end

  always @(posedge clk) begin
    mp[0] <= 64'(mul_a) * 64'(mul_b);
    for (int k = 1; k < L; k++) mp[k] <= mp[k-1];
  end
  assign mul_result = mp[L-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: scoreboard push on handshake, pop/compare on rising rsp_valid
  initial forever begin
    @(negedge clk);
    if (reset) begin
      hs_last = 4'd0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && !rsp_prev[i]) begin
          rise_cnt++;
          check("rsp_expected", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_idx", 64'(i), 64'(e.idx));
            check("rsp_val", rsp_result[64*i +: 64], e.prod);
            check("rsp_lat", 64'(cyc - e.cyc), 64'd8);
          end
        end
      end
      hs_last = req_ready & req_valid;
      if (req_ready != 4'd0) check("ready_onehot", 64'($countones(req_ready)), 64'd1);
      if (hs_last != 4'd0) exp_issue++;
      else if (req_valid != 4'd0) exp_stall++;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_last[i]) begin
          sb.push_back('{i, 64'(req_a[32*i +: 32]) * 64'(req_b[32*i +: 32]), cyc});
          grant_q.push_back(i);
          hs_cnt[i]++;
          last_hs_cyc[i] = cyc;
        end
      end
    end
    rsp_prev = reset ? 4'd0 : rsp_valid;
  end

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // advance one cycle; granted requesters load a new pair or drop valid
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs_last[i]) begin
        if (left[i] > 0) begin
          left[i]--;
          set_ops(i, $urandom, $urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset(input logic [3:0] rdy);
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 4'd0; rsp_ready = rdy;
    for (int i = 0; i < NREQ; i++) begin left[i] = 0; hs_cnt[i] = 0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete(); grant_q.delete(); exp_issue = 0; exp_stall = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rspv"}, 64'(rsp_valid), 64'd0);
    for (int i = 0; i < NREQ; i++) check({tag, "_rsp"}, rsp_result[64*i +: 64], 64'd0);
    check({tag, "_mula"}, 64'(mul_a), 64'd0);
    check({tag, "_mulb"}, 64'(mul_b), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_rsp(input int i, input int budget);
    int n = 0;
    while (!rsp_valid[i] && n < budget) begin tick(); n++; end
    check($sformatf("wait_rsp%0d", i), 64'(rsp_valid[i]), 64'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy || req_valid != 4'd0) && n < 300) begin tick(); n++; end
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sb"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int h0, h1, r0;
    reset = 1'b0; req_valid = 4'd0; req_a = '0; req_b = '0; rsp_ready = 4'hF;
    for (int i = 0; i < NREQ; i++) begin left[i] = 0; hs_cnt[i] = 0; last_hs_cyc[i] = 0; end
    #2 reset = 1'b1;
    #1 check_idle("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: single op, all-ones operands
    set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid[0] = 1'b1;
    tick();
    check("t1_busy", 64'(busy), 64'd1);
    wait_rsp(0, 20);
    check("t1_prod", rsp_result[63:0], 64'hFFFF_FFFE_0000_0001);
    check("t1_lat", 64'(cyc - last_hs_cyc[0]), 64'd8);
    drain("t1");

    // 2: all four valid together
    do_reset(4'hF);
    for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
    req_valid = 4'hF;
    drain("t2");
    check("t2_ngrant", 64'(grant_q.size()), 64'd4);
    for (int k = 0; k < grant_q.size(); k++) check("t2_order", 64'(grant_q[k]), 64'(k));

    // 3: fairness between 0 and 2
    do_reset(4'hF);
    set_ops(0, $urandom, $urandom); set_ops(2, $urandom, $urandom);
    left[0] = 3; left[2] = 3; req_valid = 4'b0101;
    drain("t3");
    check("t3_ngrant", 64'(grant_q.size()), 64'd8);
    for (int k = 1; k < grant_q.size(); k++) check("t3_alt", 64'(grant_q[k] == grant_q[k-1]), 64'd0);
    check("t3_cnt0", 64'(hs_cnt[0]), 64'd4);
    check("t3_cnt2", 64'(hs_cnt[2]), 64'd4);

    // 4: backpressure on requester 1
    do_reset(4'b1101);
    set_ops(0, $urandom, $urandom); set_ops(1, 32'd3, 32'd5); set_ops(2, $urandom, $urandom);
    left[0] = 4; left[2] = 4; req_valid = 4'b0111;
    wait_rsp(1, 30);
    check("t4_res", rsp_result[127:64], 64'd15);
    set_ops(1, 32'd7, 32'd9); req_valid[1] = 1'b1;
    h0 = hs_cnt[0]; h1 = hs_cnt[1];
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t4_hold_v", 64'(rsp_valid[1]), 64'd1);
      check("t4_hold_r", rsp_result[127:64], 64'd15);
    end
    check("t4_no_regrant", 64'(hs_cnt[1]), 64'(h1));
    check("t4_others", 64'(hs_cnt[0] > h0), 64'd1);
    rsp_ready[1] = 1'b1;
    drain("t4");

    // 5: reset three cycles after a handshake
    do_reset(4'hF);
    set_ops(0, $urandom, $urandom); req_valid[0] = 1'b1;
    for (int n = 0; n < 10 && !hs_last[0]; n++) tick();
    check("t5_hs", 64'(hs_last[0]), 64'd1);
    repeat (2) tick();
    req_valid[2] = 1'b1;
    reset = 1'b1;
    #1 check_idle("t5");
    req_valid = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    r0 = rise_cnt;
    repeat (20) tick();
    check("t5_no_rsp", 64'(rise_cnt), 64'(r0));
    check("t5_busy", 64'(busy), 64'd0);

`ifdef MUL_ARB_STATS_EN
    // 6: 10 handshakes then 4 blocked cycles
    do_reset(4'hF);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
      req_valid = 4'hF;
      drain("t6_ph");
    end
    rsp_ready = 4'b1110;
    set_ops(0, $urandom, $urandom); set_ops(1, $urandom, $urandom);
    req_valid = 4'b0011;
    wait_rsp(0, 30);
    req_valid[0] = 1'b1;
    repeat (4) tick();
    req_valid[0] = 1'b0;
    check("t6_issue", 64'(issue_count), 64'd10);
    check("t6_stall", 64'(stall_count), 64'd4);
    check("t6_issue_m", 64'(issue_count), 64'(exp_issue));
    check("t6_stall_m", 64'(stall_count), 64'(exp_stall));
    rsp_ready = 4'hF;
    drain("t6");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
